dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024; memory size in 32-bit words, a power of two, at least 16.
REQ-002 SHALL have parameter INIT_VALUE, default 32'h0000_0000; word written to every location during the init sweep.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; asynchronous active-low reset.
REQ-005 SHALL have port dmem_addr, input, 32 bits; byte address from the CPU.
REQ-006 SHALL have port dmem_data, inout, 32 bits; bidirectional data bus, driven by the CPU on writes and by this block on reads.
REQ-007 SHALL have port dmem_wen, input, 1 bit; 1 means write this cycle, 0 means read request.
REQ-008 SHALL have port init_done, output, 1 bit; high once the memory clear is complete.
REQ-009 SHALL have port err, output, 1 bit; sticky flag for a misaligned or out-of-range access.

Function
REQ-010 SHALL implement a two-state FSM with states INIT and READY, entering INIT on reset.
REQ-011 In INIT, SHALL write INIT_VALUE to word index init_ptr each cycle, with init_ptr counting 0..DEPTH-1.
REQ-012 SHALL move from INIT to READY on the cycle init_ptr == DEPTH-1 is written, so INIT lasts exactly DEPTH cycles.
REQ-013 SHALL hold init_done at 1 exactly when the state is READY.
REQ-014 In INIT, SHALL ignore CPU writes and reads and keep dmem_data at high-Z.
REQ-015 Word index SHALL be dmem_addr[log2(DEPTH)+1:2].
REQ-016 In READY with dmem_wen=1, SHALL write dmem_data to the indexed word at the rising edge.
REQ-017 In READY with dmem_wen=0, SHALL register the indexed word into rdata and set rd_valid.
REQ-018 Read latency SHALL be 1 cycle: data for a read sampled at edge N is on the bus during the cycle after edge N.
REQ-019 SHALL drive dmem_data with rdata only when rd_valid=1 and dmem_wen=0; otherwise dmem_data SHALL be high-Z (no contention with CPU writes).
REQ-020 A write at edge N followed by a read of the same address at edge N+1 SHALL return the written data.
REQ-021 A misaligned access (dmem_addr[1:0] != 0) SHALL set err and SHALL use the aligned word.
REQ-022 An out-of-range access (dmem_addr >= DEPTH*4) SHALL set err; writes SHALL be dropped and reads SHALL return 32'h0.
REQ-023 Once set, err SHALL stay 1 until reset.

Reset
REQ-024 Asserting rst_n low SHALL immediately force state=INIT, init_ptr=0, rd_valid=0, rdata=0, err=0, init_done=0 and dmem_data to high-Z.
REQ-025 A reset during READY or mid-INIT SHALL restart the full DEPTH-cycle sweep.

Configuration
REQ-026 Defining macro DMEM_RESPONDER_COUNTERS_EN SHALL add 32-bit output ports rd_count and wr_count.
REQ-027 With the macro defined, rd_count and wr_count SHALL count accepted READY-state reads and writes (including those that set err), reset to 0 and wrap modulo 2^32.
REQ-028 Without the macro, the counter ports and logic SHALL be absent, with all other behaviour identical.

Structure
REQ-029 Package dmem_pkg SHALL hold the FSM state enum (INIT, READY), the word width constant (32) and the default DEPTH.
REQ-030 SHALL contain one sub-module, dmem_sram: a single-port synchronous RAM with a write port and a registered read port, owned by the FSM.

Verification
REQ-031 Reset, then run DEPTH=16 -> init_done rises 16 cycles after rst_n deasserts, and dmem_data stays Z throughout.
REQ-032 Write 32'hDEAD_BEEF to 0x8, then read 0x8 on the next cycle -> the bus shows 32'hDEAD_BEEF one cycle later, and err=0.
REQ-033 Read 0x4 after init with INIT_VALUE=32'hA5A5_A5A5 -> returns 32'hA5A5_A5A5.
REQ-034 Write to 0x6 -> err=1 and word 1 is updated; then write to 0x40 with DEPTH=16 -> dropped, a read of 0x40 returns 0, and err stays 1.
REQ-035 Assert rst_n mid-INIT at cycle 7 -> init_done=0 immediately and the sweep restarts with a full 16 cycles.
REQ-036 With COUNTERS_EN, perform 3 writes and 5 reads -> wr_count=3 and rd_count=5; reset -> both 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory responder.
//   WORD_W    : data word width in bits
//   DEPTH_DEF : default memory depth in words
//   state_t   : responder FSM state (INIT = clear sweep, READY = serving CPU)
// ----------------------------------------------------------------------------
package dmem_pkg;

    localparam int WORD_W    = 32;
    localparam int DEPTH_DEF = 1024;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

endpackage : dmem_pkg

// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_responder_if
// CPU-side control/status bundle for dmem_responder. The bidirectional data
// bus stays a plain inout port on the responder so the tristate resolves on
// an ordinary net.
//   dmem_addr : byte address from the CPU
//   dmem_wen  : 1 = write this cycle, 0 = read request
//   init_done : memory clear complete
//   err       : sticky misaligned / out-of-range flag
// Modports: master (CPU side), slave (responder side).
// ----------------------------------------------------------------------------
interface dmem_responder_if;
    import dmem_pkg::*;

    logic [WORD_W-1:0] dmem_addr;
    logic              dmem_wen;
    logic              init_done;
    logic              err;

    modport master (
        output dmem_addr,
        output dmem_wen,
        input  init_done,
        input  err
    );

    modport slave (
        input  dmem_addr,
        input  dmem_wen,
        output init_done,
        output err
    );

endinterface : dmem_responder_if

// File: rtl/dmem_sram.sv
// ----------------------------------------------------------------------------
// dmem_sram
// Single-port synchronous RAM with a registered read port.
//   clk, rst_n : clock, async active-low reset (clears the read register only)
//   i_we       : write enable
//   i_addr     : word index
//   i_wdata    : write data
//   i_re       : read enable, loads o_rdata at the rising edge
//   i_rzero    : on a read, load zero instead of the array word
//   o_rdata    : registered read data
// ----------------------------------------------------------------------------
module dmem_sram
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic              i_rzero,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    // Array has no reset; the owner clears it with an explicit sweep.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_rzero ? '0 : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : dmem_sram

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for a simple CPU. After reset it clears every word to
// INIT_VALUE (one word per cycle, DEPTH cycles), then serves one access per
// cycle: dmem_wen=1 writes, dmem_wen=0 reads with one cycle of latency.
// Misaligned addresses use the aligned word and set err; out-of-range
// addresses set err, drop writes and read as zero. err is sticky until reset.
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : async active-low reset
//   bus       : dmem_responder_if.slave (dmem_addr, dmem_wen, init_done, err)
//   dmem_data : inout data bus, driven here only for read data
//   rd_count / wr_count : accepted READY reads / writes
//                         (only with DMEM_RESPONDER_COUNTERS_EN defined)
//
// Configuration macro: DMEM_RESPONDER_COUNTERS_EN
// ----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int                DEPTH      = DEPTH_DEF,
    parameter logic [WORD_W-1:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   bus,
    inout  wire  [WORD_W-1:0] dmem_data
`ifdef DMEM_RESPONDER_COUNTERS_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`endif
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [32:0] BYTES = 33'(DEPTH) * 33'd4;

    state_t            r_state;
    logic [AW-1:0]     r_init_ptr;
    logic              r_init_done;
    logic              r_rd_valid;
    logic              r_err;

    logic              w_ready;
    logic              w_in_range;
    logic              w_misal;
    logic [AW-1:0]     w_idx;
    logic              w_we;
    logic [AW-1:0]     w_addr;
    logic [WORD_W-1:0] w_wdata;
    logic              w_re;
    logic [WORD_W-1:0] w_rdata;

    assign w_ready    = (r_state == READY);
    assign w_in_range = ({1'b0, bus.dmem_addr} < BYTES);
    assign w_misal    = (bus.dmem_addr[1:0] != 2'b00);
    assign w_idx      = bus.dmem_addr[AW+1:2];

    // The sweep owns the RAM port during INIT; CPU traffic is ignored then.
    assign w_we    = w_ready ? (bus.dmem_wen && w_in_range) : 1'b1;
    assign w_addr  = w_ready ? w_idx : r_init_ptr;
    assign w_wdata = w_ready ? dmem_data : INIT_VALUE;
    assign w_re    = w_ready && !bus.dmem_wen;

    dmem_sram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_rzero (!w_in_range),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INIT;
            r_init_ptr  <= '0;
            r_init_done <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_rd_valid <= 1'b0;
                    r_init_ptr <= r_init_ptr + 1'b1;
                    if (r_init_ptr == AW'(DEPTH - 1)) begin
                        r_state     <= READY;
                        r_init_done <= 1'b1;
                    end
                end
                READY: begin
                    r_rd_valid <= !bus.dmem_wen;
                    if (w_misal || !w_in_range) r_err <= 1'b1;
                end
                default: begin
                    r_state     <= INIT;
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    // Drive only while the CPU is reading, so a CPU write never contends.
    assign dmem_data = (r_rd_valid && !bus.dmem_wen) ? w_rdata : 'z;

    assign bus.init_done = r_init_done;
    assign bus.err       = r_err;

`ifdef DMEM_RESPONDER_COUNTERS_EN
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (w_ready) begin
            if (bus.dmem_wen) r_wr_count <= r_wr_count + 32'd1;
            else              r_rd_count <= r_rd_count + 32'd1;
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder with DEPTH=16, INIT_VALUE=A5A5_A5A5.
// The data bus carries a pullup, so an undriven bus reads as all ones.
// ----------------------------------------------------------------------------
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int          DEPTH = 16;
    localparam logic [31:0] IVAL  = 32'hA5A5_A5A5;
    localparam logic [31:0] FLOAT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tb_drv;
    logic [31:0] tb_wdata;
    wire  [31:0] dmem_data;

    int n_chk = 0;
    int n_err = 0;

    dmem_responder_if bus ();

    pullup (dmem_data);
    assign dmem_data = tb_drv ? tb_wdata : 'z;

`ifdef DMEM_RESPONDER_COUNTERS_EN
    logic [31:0] rd_count, wr_count;
`endif

    dmem_responder #(
        .DEPTH      (DEPTH),
        .INIT_VALUE (IVAL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dmem_data (dmem_data)
`ifdef DMEM_RESPONDER_COUNTERS_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One access cycle: set inputs at a falling edge, return at the next one.
    task automatic cyc(input logic [31:0] a, input logic w, input logic [31:0] d);
        bus.dmem_addr = a;
        bus.dmem_wen  = w;
        tb_drv        = w;
        tb_wdata      = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Release reset at a falling edge and follow the full clear sweep.
    task automatic run_init(input string tag);
        int zbad = 0;
        bus.dmem_addr = 32'h0;
        bus.dmem_wen  = 1'b0;
        tb_drv        = 1'b0;
        rst_n         = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (dmem_data !== FLOAT) zbad++;
            if (i == DEPTH - 1) chk({tag, "_done_early"}, 32'(bus.init_done), 32'd0);
            if (i == DEPTH)     chk({tag, "_done"},       32'(bus.init_done), 32'd1);
        end
        chk({tag, "_bus_z"}, 32'(zbad), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        tb_drv        = 1'b0;
        tb_wdata      = 32'h0;
        bus.dmem_addr = 32'h0;
        bus.dmem_wen  = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_init_done", 32'(bus.init_done), 32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        chk("rst_bus_z",     dmem_data,          FLOAT);

        run_init("init1");

        cyc(32'h4, 1'b0, 32'h0);
        chk("rd_init_val", dmem_data, IVAL);

        cyc(32'h8, 1'b1, 32'hDEAD_BEEF);
        cyc(32'h8, 1'b0, 32'h0);
        chk("wr_rd_8",  dmem_data,     32'hDEAD_BEEF);
        chk("err_ok",   32'(bus.err),  32'd0);

        cyc(32'h6, 1'b1, 32'h1234_5678);
        chk("misal_err", 32'(bus.err), 32'd1);
        cyc(32'h4, 1'b0, 32'h0);
        chk("misal_word1", dmem_data, 32'h1234_5678);

        cyc(32'h40, 1'b1, 32'hCAFE_F00D);
        cyc(32'h40, 1'b0, 32'h0);
        chk("oor_rd_zero", dmem_data,    32'h0);
        chk("oor_err",     32'(bus.err), 32'd1);
        cyc(32'h0, 1'b0, 32'h0);
        chk("oor_no_alias", dmem_data, IVAL);

        // Switch from read to write: the responder must release the bus.
        bus.dmem_addr = 32'hC;
        bus.dmem_wen  = 1'b1;
        tb_drv        = 1'b1;
        tb_wdata      = 32'h0;
        #1;
        chk("no_contend", dmem_data, 32'h0);
        @(posedge clk);
        @(negedge clk);
        cyc(32'hC, 1'b0, 32'h0);
        chk("wr_rd_c", dmem_data, 32'h0);

        // Reset while READY with a read on the bus.
        rst_n = 1'b0;
        #1;
        chk("rst_rdy_done", 32'(bus.init_done), 32'd0);
        chk("rst_rdy_err",  32'(bus.err),       32'd0);
        chk("rst_rdy_bus",  dmem_data,          FLOAT);
        @(negedge clk);

        // Reset part-way through the sweep.
        rst_n = 1'b1;
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_done", 32'(bus.init_done), 32'd0);
        @(negedge clk);
        run_init("init2");

`ifdef DMEM_RESPONDER_COUNTERS_EN
        cyc(32'h0, 1'b1, 32'h1);
        cyc(32'h4, 1'b1, 32'h2);
        cyc(32'h8, 1'b1, 32'h3);
        repeat (5) cyc(32'h0, 1'b0, 32'h0);
        chk("wr_count", wr_count, 32'd3);
        chk("rd_count", rd_count, 32'd5);
        chk("cnt_rd_data", dmem_data, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("wr_count_rst", wr_count, 32'd0);
        chk("rd_count_rst", rd_count, 32'd0);
        @(negedge clk);
        run_init("init3");
`endif

        // The sweep after the restart cleared the earlier write.
        cyc(32'h8, 1'b0, 32'h0);
        chk("swept_8", dmem_data, IVAL);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule : tb_dmem_responder
